// File: rtl/io_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and a divisor helper.
package io_uart_tx_pkg;

    localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;
    localparam logic [3:0] UART_DIV_OFS    = 4'h8;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_MSB   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // A zero divisor would stall the baud counter, so it is promoted to one.
    function automatic logic [15:0] div_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/io_uart_tx_fifo.sv
// Byte-wide synchronous TX FIFO with clock enable. Pointers carry one extra
// bit so that full and empty are distinguishable.
module io_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clk_en,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [7:0]                 i_data,
    output logic [7:0]                 o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is still taken when a pop frees a slot the same cycle.
    assign w_do_pop  = i_clk_en & i_pop & ~o_empty;
    assign w_do_push = i_clk_en & i_push & (~o_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FSM, baud counter
// and shift register around a small byte FIFO.
module io_uart_tx
    import io_uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 868
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic        i_io_en,
    input  logic        i_mem_write,
    input  logic [3:0]  i_addr,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_rd_data,
    output logic        o_tx,
    output logic        o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    tx_state_t   r_state;
    tx_state_t   w_state_next;
    logic [15:0] r_baud_cnt;
    logic [15:0] w_baud_cnt_next;
    logic [15:0] r_frame_div;
    logic [15:0] w_frame_div_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic        r_tx;
    logic        w_tx_next;
    logic [15:0] r_div;
    logic        r_ovf;

    logic        w_wr;
    logic        w_push;
    logic        w_pop;
    logic        w_baud_done;
    logic [7:0]  w_fifo_data;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [AW:0] w_fifo_count;
    logic [31:0] w_status;
    logic [31:0] w_rd_data;
    logic        w_unused;

    assign w_unused    = ^i_wr_data[31:16];
    assign w_wr        = i_clk_en & i_io_en & i_mem_write;
    assign w_push      = w_wr & (i_addr == UART_TXDATA_OFS);
    assign w_baud_done = (r_baud_cnt == 16'd0);

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clk_en (i_clk_en),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_data   (i_wr_data[7:0]),
        .o_data   (w_fifo_data),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty),
        .o_count  (w_fifo_count)
    );

    // Next-state logic; the divisor is captured per frame so BAUD_DIV writes apply to the next frame.
    always_comb begin
        w_state_next     = r_state;
        w_baud_cnt_next  = r_baud_cnt;
        w_frame_div_next = r_frame_div;
        w_shift_next     = r_shift;
        w_bit_idx_next   = r_bit_idx;
        w_pop            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop            = 1'b1;
                    w_shift_next     = w_fifo_data;
                    w_frame_div_next = r_div;
                    w_baud_cnt_next  = r_div - 16'd1;
                    w_state_next     = S_START;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_next    = S_DATA;
                    w_bit_idx_next  = 3'd0;
                    w_baud_cnt_next = r_frame_div - 16'd1;
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_shift_next    = {1'b0, r_shift[7:1]};
                    w_baud_cnt_next = r_frame_div - 16'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    if (!w_fifo_empty) begin
                        w_pop            = 1'b1;
                        w_shift_next     = w_fifo_data;
                        w_frame_div_next = r_div;
                        w_baud_cnt_next  = r_div - 16'd1;
                        w_state_next     = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt - 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        case (w_state_next)
            S_IDLE:  w_tx_next = 1'b1;
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            S_STOP:  w_tx_next = 1'b1;
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= 16'd0;
            r_frame_div <= 16'(DEFAULT_DIV);
            r_shift     <= 8'd0;
            r_bit_idx   <= 3'd0;
            r_tx        <= 1'b1;
        end else if (i_clk_en) begin
            r_state     <= w_state_next;
            r_baud_cnt  <= w_baud_cnt_next;
            r_frame_div <= w_frame_div_next;
            r_shift     <= w_shift_next;
            r_bit_idx   <= w_bit_idx_next;
            r_tx        <= w_tx_next;
        end
    end

    // Overflow is set only when a full FIFO cannot make room the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= 16'(DEFAULT_DIV);
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (i_addr == UART_DIV_OFS)) begin
                r_div <= div_sanitize(i_wr_data[15:0]);
            end
            if (w_push && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (i_addr == UART_STATUS_OFS) && i_wr_data[ST_OVF_BIT]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                        = 32'd0;
        w_status[ST_FULL_BIT]           = w_fifo_full;
        w_status[ST_EMPTY_BIT]          = w_fifo_empty;
        w_status[ST_BUSY_BIT]           = o_busy;
        w_status[ST_OVF_BIT]            = r_ovf;
        w_status[ST_CNT_MSB:ST_CNT_LSB] = 5'(w_fifo_count);
        case (i_addr)
            UART_STATUS_OFS: w_rd_data = w_status;
            UART_DIV_OFS:    w_rd_data = {16'd0, r_div};
            default:         w_rd_data = 32'd0;
        endcase
    end

    assign o_rd_data = w_rd_data;
    assign o_tx      = r_tx;
    assign o_busy    = (r_state != S_IDLE) | ~w_fifo_empty;

endmodule
